// File: rtl/scaler_h_step_ctrl_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | scaler_h_step_ctrl_pkg : shared defaults and FSM encodings for the scaler |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
package scaler_h_step_ctrl_pkg;

  localparam int PIXEL_STEP_DEF = 4096;
  localparam int WIDTH_BITS_DEF = 12;
  localparam int STEP_WIDTH_DEF = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

endpackage
`default_nettype wire

// File: rtl/scaler_div_restoring.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | scaler_div_restoring : serial restoring divider, one quotient bit per clk |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module scaler_div_restoring #(
  parameter int N = 24,
  parameter int M = 12,
  parameter int Q = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         done,
  output logic [Q-1:0] quotient,
  output logic         overflow
);

  localparam int CW = $clog2(N + 1);

  logic          running;
  logic [CW-1:0] cnt;
  logic [N-1:0]  quo;
  logic [M-1:0]  rem;
  logic [M-1:0]  dsr;

  logic [N-1:0]  src_q;
  logic [M-1:0]  src_r;
  logic [M-1:0]  src_d;
  logic [M:0]    shifted;
  logic [M:0]    diff;
  logic          ge;
  logic [N-1:0]  next_q;
  logic [M-1:0]  next_r;

  // The start cycle already performs the first iteration, so N bits take N clocks.
  always_comb begin
    src_q   = start ? dividend : quo;
    src_r   = start ? '0 : rem;
    src_d   = start ? divisor : dsr;
    shifted = {src_r, src_q[N-1]};
    diff    = shifted - {1'b0, src_d};
    ge      = (shifted >= {1'b0, src_d});
    next_r  = ge ? diff[M-1:0] : shifted[M-1:0];
    next_q  = {src_q[N-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dsr     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo     <= next_q;
        rem     <= next_r;
        dsr     <= divisor;
        cnt     <= CW'(N - 1);
        running <= 1'b1;
      end else if (abort) begin
        running <= 1'b0;
      end else if (running) begin
        quo <= next_q;
        rem <= next_r;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  generate
    if (N > Q) begin : g_ovf
      assign quotient = quo[Q-1:0];
      assign overflow = |quo[N-1:Q];
    end else begin : g_no_ovf
      assign quotient = Q'(quo);
      assign overflow = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/scaler_h_step_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | scaler_h_step_ctrl : computes scale_step and applies it on a frame edge   |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module scaler_h_step_ctrl
  import scaler_h_step_ctrl_pkg::*;
#(
  parameter int PIXEL_STEP = PIXEL_STEP_DEF,
  parameter int WIDTH_BITS = WIDTH_BITS_DEF,
  parameter int STEP_WIDTH = STEP_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH_BITS-1:0] cfg_in_width_i,
  input  logic [WIDTH_BITS-1:0] cfg_out_width_i,
  input  logic                  cfg_wr_i,
  input  logic                  vs_i,
  output logic [STEP_WIDTH-1:0] scale_step_o,
  output logic                  busy_o,
  output logic                  pending_o,
  output logic                  applied_o,
  output logic                  cfg_err_o
);

  localparam int FRAC_BITS = $clog2(PIXEL_STEP);
  localparam int DIV_BITS  = WIDTH_BITS + FRAC_BITS;

  logic [1:0]            state;
  logic                  vs_d;
  logic [STEP_WIDTH-1:0] shadow;

  logic                  zero_cfg;
  logic                  div_start;
  logic                  div_abort;
  logic [DIV_BITS-1:0]   dividend;
  logic                  div_done;
  logic [STEP_WIDTH-1:0] div_quot;
  logic                  div_ovf;
  logic [STEP_WIDTH-1:0] div_sat;
  logic                  vs_rise;

  // Half the divisor is added up front so the truncating divide rounds to nearest.
  always_comb begin
    zero_cfg  = (cfg_in_width_i == '0) || (cfg_out_width_i == '0);
    div_start = cfg_wr_i & ~zero_cfg;
    div_abort = cfg_wr_i & zero_cfg;
    dividend  = (DIV_BITS'(cfg_in_width_i) << FRAC_BITS)
              + DIV_BITS'(cfg_out_width_i >> 1);
    div_sat   = div_ovf ? '1 : div_quot;
    vs_rise   = vs_i & ~vs_d;
  end

  scaler_div_restoring #(
    .N (DIV_BITS),
    .M (WIDTH_BITS),
    .Q (STEP_WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (dividend),
    .divisor  (cfg_out_width_i),
    .done     (div_done),
    .quotient (div_quot),
    .overflow (div_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      vs_d         <= 1'b0;
      shadow       <= '0;
      scale_step_o <= STEP_WIDTH'(PIXEL_STEP);
      applied_o    <= 1'b0;
      cfg_err_o    <= 1'b0;
    end else begin
      vs_d      <= vs_i;
      applied_o <= 1'b0;
      // A new configuration always wins over a completing divide or a frame edge.
      if (cfg_wr_i) begin
        cfg_err_o <= zero_cfg;
        state     <= zero_cfg ? S_IDLE : S_DIV;
      end else begin
        case (state)
          S_DIV: begin
            if (div_done) begin
              shadow <= div_sat;
              if (div_ovf) cfg_err_o <= 1'b1;
              state  <= S_PEND;
            end
          end
          S_PEND: begin
            if (vs_rise) begin
              scale_step_o <= shadow;
              applied_o    <= 1'b1;
              state        <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_o    = (state == S_DIV);
  assign pending_o = (state == S_PEND);

endmodule
`default_nettype wire
